// File: rtl/vend_if.sv
// Coin front-end to vend controller bundle: coin strobes and cancel in, credit and
// actuator pulses out.
interface vend_if #(
   parameter int unsigned CREDIT_W = 8
);
   logic                coin_valid;
   logic [1:0]          coin_sel;
   logic                cancel;
   logic [CREDIT_W-1:0] credit;
   logic                vend;
   logic                change_pulse;
   logic                coin_reject;
   logic                busy;

   // Front-end side: drives coins and cancel, observes the controller.
   modport master (
      output coin_valid,
      output coin_sel,
      output cancel,
      input  credit,
      input  vend,
      input  change_pulse,
      input  coin_reject,
      input  busy
   );

   modport slave (
      input  coin_valid,
      input  coin_sel,
      input  cancel,
      output credit,
      output vend,
      output change_pulse,
      output coin_reject,
      output busy
   );
endinterface

// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, pulses vend once the price is reached,
// then returns the remainder (or a cancelled credit) one change unit per cycle.
module vend_controller #(
   parameter int unsigned PRICE       = 25,
   parameter int unsigned CHANGE_UNIT = 5,
   parameter int unsigned MAX_CREDIT  = 95,
   parameter int unsigned CREDIT_W    = 8
) (
   input logic   clk,
   input logic   reset,
   vend_if.slave bus
);

   localparam int unsigned SumW = CREDIT_W + 1;

   localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] UnitC  = CREDIT_W'(CHANGE_UNIT);
   localparam logic [SumW-1:0]     PriceW = SumW'(PRICE);
   localparam logic [SumW-1:0]     MaxW   = SumW'(MAX_CREDIT);

   typedef enum logic [1:0] {
      StIdle,
      StCredit,
      StVend,
      StChange
   } state_e;

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                coin_reject_q, coin_reject_d;

   logic [SumW-1:0]     coin_val;
   logic [SumW-1:0]     credit_sum;
   logic                coin_ok;

   always_comb begin
      coin_val = '0;
      unique case (bus.coin_sel)
         2'd0:    coin_val = SumW'(5);
         2'd1:    coin_val = SumW'(10);
         2'd2:    coin_val = SumW'(20);
         default: coin_val = '0;
      endcase
   end

   // One bit wider than credit so an over-ceiling sum can never wrap into range.
   assign credit_sum = {1'b0, credit_q} + coin_val;

   assign coin_ok = bus.coin_valid && (bus.coin_sel != 2'd3) && !bus.cancel &&
                    (credit_sum <= MaxW);

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      coin_reject_d = 1'b0;

      unique case (state_q)
         StIdle, StCredit: begin
            // cancel wins over a same-cycle coin; coin_ok already excludes cancel.
            coin_reject_d = bus.coin_valid && !coin_ok;
            if ((state_q == StCredit) && bus.cancel) begin
               state_d = StChange;
            end else if (coin_ok) begin
               credit_d = credit_sum[CREDIT_W-1:0];
               state_d  = (credit_sum >= PriceW) ? StVend : StCredit;
            end
         end
         StVend: begin
            coin_reject_d = bus.coin_valid;
            credit_d      = credit_q - PriceC;
            state_d       = (credit_q > PriceC) ? StChange : StIdle;
         end
         StChange: begin
            coin_reject_d = bus.coin_valid;
            if (credit_q <= UnitC) begin
               credit_d = '0;
               state_d  = StIdle;
            end else begin
               credit_d = credit_q - UnitC;
            end
         end
         default: begin
            state_d  = StIdle;
            credit_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         credit_q      <= '0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   assign bus.credit       = credit_q;
   assign bus.vend         = (state_q == StVend);
   assign bus.change_pulse = (state_q == StChange);
   assign bus.busy         = (state_q == StVend) || (state_q == StChange);
   assign bus.coin_reject  = coin_reject_q;

   a_no_overlap: assert property (@(posedge clk) disable iff (reset)
      !(bus.vend && bus.change_pulse));
   a_credit_unit: assert property (@(posedge clk) disable iff (reset)
      (32'(credit_q) % CHANGE_UNIT) == 0);
   a_credit_ceiling: assert property (@(posedge clk) disable iff (reset)
      32'(credit_q) <= MAX_CREDIT);

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed vector table, reset/overflow sequences, and random
// traffic against a credit/refund-count reference model on two parameter sets.
module tb_vend_controller;

   localparam int CU = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vend_if #(.CREDIT_W(8)) a_if ();
   vend_if #(.CREDIT_W(8)) b_if ();

   vend_controller #(
      .PRICE(25), .CHANGE_UNIT(5), .MAX_CREDIT(95), .CREDIT_W(8)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(a_if.slave)
   );

   // Higher price with a tight ceiling so the overflow reject is reachable.
   vend_controller #(
      .PRICE(50), .CHANGE_UNIT(5), .MAX_CREDIT(55), .CREDIT_W(8)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(b_if.slave)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit       cv;
      bit [1:0] cs;
      bit       cn;
      int       credit;
      bit       vend;
      bit       chg;
      bit       rej;
      bit       busy;
   } vec_t;

   // Reference: credit, a pending sale flag, and the number of change pulses still owed.
   typedef struct {
      int credit;
      bit sale;
      int refund;
      bit rej;
   } mdl_t;

   function automatic mdl_t mdl_clear();
      mdl_t m;
      m.credit = 0; m.sale = 0; m.refund = 0; m.rej = 0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, bit cv, bit [1:0] cs, bit cn, int price, int maxc);
      mdl_t n;
      int   v;
      n     = m;
      n.rej = 0;
      v     = (cs == 0) ? 5 : (cs == 1) ? 10 : (cs == 2) ? 20 : 0;
      if (m.sale) begin
         n.credit = m.credit - price;
         n.sale   = 0;
         n.refund = n.credit / CU;
         n.rej    = cv;
      end else if (m.refund > 0) begin
         n.credit = m.credit - CU;
         n.refund = m.refund - 1;
         n.rej    = cv;
      end else begin
         if (cv) begin
            if (cs != 3 && !cn && (m.credit + v) <= maxc) begin
               n.credit = m.credit + v;
               n.sale   = (n.credit >= price);
            end else begin
               n.rej = 1;
            end
         end
         if (cn && m.credit > 0) n.refund = m.credit / CU;
      end
      return n;
   endfunction

   task automatic check(input string nm, input int idx, input logic [7:0] c, input logic v,
                        input logic ch, input logic rj, input logic bz, input int ec,
                        input bit ev, input bit ech, input bit erj, input bit ebz);
      checks++;
      if (c !== 8'(ec) || v !== ev || ch !== ech || rj !== erj || bz !== ebz) begin
         failures++;
         $display("FAIL %s[%0d]: got credit=%0d vend=%b change=%b reject=%b busy=%b, want credit=%0d vend=%b change=%b reject=%b busy=%b",
                  nm, idx, c, v, ch, rj, bz, ec, ev, ech, erj, ebz);
      end
   endtask

   task automatic chk_a(input string nm, input int idx, input int ec, input bit ev,
                        input bit ech, input bit erj, input bit ebz);
      check(nm, idx, a_if.credit, a_if.vend, a_if.change_pulse, a_if.coin_reject, a_if.busy,
            ec, ev, ech, erj, ebz);
   endtask

   task automatic chk_b(input string nm, input int idx, input int ec, input bit ev,
                        input bit ech, input bit erj, input bit ebz);
      check(nm, idx, b_if.credit, b_if.vend, b_if.change_pulse, b_if.coin_reject, b_if.busy,
            ec, ev, ech, erj, ebz);
   endtask

   task automatic chk_mdl_a(input string nm, input int idx, input mdl_t m);
      bit ev, ech;
      ev  = m.sale;
      ech = !m.sale && (m.refund > 0);
      chk_a(nm, idx, m.credit, ev, ech, m.rej, ev | ech);
   endtask

   task automatic chk_mdl_b(input string nm, input int idx, input mdl_t m);
      bit ev, ech;
      ev  = m.sale;
      ech = !m.sale && (m.refund > 0);
      chk_b(nm, idx, m.credit, ev, ech, m.rej, ev | ech);
   endtask

   // Drive both DUTs, then sample 1 time unit after the edge.
   task automatic step(input bit av, input bit [1:0] as, input bit an,
                       input bit bv, input bit [1:0] bs, input bit bn);
      a_if.coin_valid = av; a_if.coin_sel = as; a_if.cancel = an;
      b_if.coin_valid = bv; b_if.coin_sel = bs; b_if.cancel = bn;
      @(posedge clk);
      #1;
   endtask

   task automatic step_a(input bit av, input bit [1:0] as, input bit an);
      step(av, as, an, 1'b0, 2'd0, 1'b0);
   endtask

   vec_t tbl[$];
   mdl_t ma, mb;

   initial begin
      //            cv cs cn  credit vend chg rej busy
      tbl.push_back('{1, 0, 0,  5, 0, 0, 0, 0});  // T1: 5
      tbl.push_back('{1, 2, 0, 25, 1, 0, 0, 1});  //     +20 -> vend
      tbl.push_back('{0, 0, 0,  0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 0,  0, 0, 0, 0, 0});
      tbl.push_back('{1, 2, 0, 20, 0, 0, 0, 0});  // T2: 20
      tbl.push_back('{1, 2, 0, 40, 1, 0, 0, 1});  //     +20 -> vend
      tbl.push_back('{0, 0, 0, 15, 0, 1, 0, 1});
      tbl.push_back('{0, 0, 0, 10, 0, 1, 0, 1});
      tbl.push_back('{0, 0, 0,  5, 0, 1, 0, 1});
      tbl.push_back('{0, 0, 0,  0, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 0, 10, 0, 0, 0, 0});  // T3: 10
      tbl.push_back('{0, 0, 1, 10, 0, 1, 0, 1});  //     cancel
      tbl.push_back('{0, 0, 0,  5, 0, 1, 0, 1});
      tbl.push_back('{0, 0, 0,  0, 0, 0, 0, 0});
      tbl.push_back('{1, 3, 0,  0, 0, 0, 1, 0});  // T4: invalid coin in IDLE
      tbl.push_back('{1, 2, 0, 20, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 0, 30, 1, 0, 0, 1});
      tbl.push_back('{1, 0, 0,  5, 0, 1, 1, 1});  //     coin during VEND
      tbl.push_back('{1, 0, 0,  0, 0, 0, 1, 0});  //     coin during CHANGE
      tbl.push_back('{0, 0, 0,  0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0,  5, 0, 0, 0, 0});  // T5: 5
      tbl.push_back('{1, 1, 1,  5, 0, 1, 1, 1});  //     10 + cancel
      tbl.push_back('{0, 0, 0,  0, 0, 0, 0, 0});
      tbl.push_back('{0, 0, 1,  0, 0, 0, 0, 0});  // cancel in IDLE ignored
      tbl.push_back('{1, 0, 1,  0, 0, 0, 1, 0});  // coin + cancel in IDLE rejected

      reset = 1'b1;
      step_a(1'b0, 2'd0, 1'b0);
      reset = 1'b0;
      chk_a("reset_a", 0, 0, 0, 0, 0, 0);
      chk_b("reset_b", 0, 0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         step_a(tbl[i].cv, tbl[i].cs, tbl[i].cn);
         chk_a("table", i, tbl[i].credit, tbl[i].vend, tbl[i].chg, tbl[i].rej, tbl[i].busy);
      end

      // T6: reset while paying out change with credit 10.
      step_a(1'b1, 2'd2, 1'b0);
      step_a(1'b1, 2'd2, 1'b0);
      step_a(1'b0, 2'd0, 1'b0);
      step_a(1'b0, 2'd0, 1'b0);
      chk_a("t6_pre", 0, 10, 0, 1, 0, 1);
      reset = 1'b1;
      step_a(1'b0, 2'd0, 1'b0);
      reset = 1'b0;
      chk_a("t6_reset", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step_a(1'b0, 2'd0, 1'b0);
         chk_a("t6_quiet", i, 0, 0, 0, 0, 0);
      end

      // Reset during VEND suppresses the following change pulse.
      step_a(1'b1, 2'd2, 1'b0);
      step_a(1'b1, 2'd1, 1'b0);
      chk_a("vend_pre", 0, 30, 1, 0, 0, 1);
      reset = 1'b1;
      step_a(1'b0, 2'd0, 1'b0);
      reset = 1'b0;
      step_a(1'b0, 2'd0, 1'b0);
      chk_a("vend_reset", 0, 0, 0, 0, 0, 0);

      // Ceiling on the PRICE=50 / MAX_CREDIT=55 instance.
      step(1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0);
      chk_b("cap", 0, 20, 0, 0, 0, 0);
      step(1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0);
      chk_b("cap", 1, 40, 0, 0, 0, 0);
      step(1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0);
      chk_b("cap_over", 2, 40, 0, 0, 1, 0);
      step(1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0);
      chk_b("cap", 3, 50, 1, 0, 0, 1);
      step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
      chk_b("cap", 4, 0, 0, 0, 0, 0);

      // Random traffic, identical stimulus to both instances.
      reset = 1'b1;
      step(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
      reset = 1'b0;
      ma = mdl_clear();
      mb = mdl_clear();
      for (int i = 0; i < 3000; i++) begin
         bit       cv, cn, rs;
         bit [1:0] cs;
         rs    = ($urandom_range(63) == 0);
         cv    = 1'($urandom_range(1));
         cs    = 2'($urandom_range(3));
         cn    = ($urandom_range(7) == 0);
         reset = rs;
         step(cv, cs, cn, cv, cs, cn);
         reset = 1'b0;
         if (rs) begin
            ma = mdl_clear();
            mb = mdl_clear();
         end else begin
            ma = mdl_step(ma, cv, cs, cn, 25, 95);
            mb = mdl_step(mb, cv, cs, cn, 50, 55);
         end
         chk_mdl_a("rand_a", i, ma);
         chk_mdl_b("rand_b", i, mb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
